multicycle_mem_responder: RTL
=============================

Name: multicycle_mem_responder

Overview:
- Data-memory responder for the next CPU revision, in which memory no longer answers in the same cycle.
- The CPU (requester) issues a read or write with a valid/ready handshake. This block models a fixed-latency memory, 4 cycles by default, with one outstanding request.
- It returns a one-cycle response pulse carrying read data or a write acknowledge. It replaces the single-cycle data memory behind the CPU's data-memory port.

Parameters:
- ADDR_WIDTH, 16, width of the request byte address.
- DATA_WIDTH, 16, width of a memory word.
- DEPTH_LOG2, 10, log2 of the number of words in the array. Must be <= ADDR_WIDTH-1.
- LATENCY, 4, number of cycles from accept edge to response edge. Must be >= 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  requester has a request.
- req_wr  input  1  1 = write, 0 = read. Sampled on accept.
- req_addr  input  ADDR_WIDTH  byte address. Sampled on accept.
- req_wdata  input  DATA_WIDTH  write data. Sampled on accept.
- req_ready  output  1  block can accept a request this cycle.
- rsp_valid  output  1  one-cycle pulse marking completion of the accepted request.
- rsp_rdata  output  DATA_WIDTH  read data. Valid when rsp_valid=1 on a read.
- busy  output  1  a request is outstanding (state WAIT or RESP).

Behaviour:
- Reset is asynchronous and active-low; one clock domain (clk).
- Reset values: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, busy=0, internal counter and latched request registers=0.
- Memory array contents are NOT cleared by reset.
- Word index = req_addr[DEPTH_LOG2:1]. Bit 0 is ignored, so words are aligned. Upper address bits are ignored, so indexing wraps modulo 2^DEPTH_LOG2.
- Accept: req_valid & req_ready at a rising edge (call it edge k). At edge k the block latches req_wr, the index and req_wdata.
- req_valid while req_ready=0 is ignored, with no side effects. The requester must hold or re-present the request.
- States:
  - IDLE: req_ready=1, busy=0. On accept: go to WAIT with cnt <= LATENCY-2.
  - WAIT: req_ready=0, busy=1. If cnt==0 go to RESP, else cnt decrements.
    - On the WAIT->RESP edge a read registers rsp_rdata <= mem[index].
    - On the WAIT->RESP edge a write commits mem[index] <= wdata; rsp_rdata is unchanged.
  - RESP: rsp_valid=1 for exactly this one cycle, busy=1, req_ready=1.
    - Accept in RESP: go to WAIT with cnt <= LATENCY-2 (back-to-back operation).
    - No accept in RESP: go to IDLE.
- Latency: rsp_valid is sampled high at edge k+LATENCY. Peak throughput is one request per LATENCY cycles.
- rsp_rdata holds its last read value outside RESP. It changes only on a read's WAIT->RESP edge or on reset.
- Ordering: a write's commit edge precedes any later read's data-capture edge. A read issued back-to-back after a write to the same word therefore returns the new data.
- Reset mid-operation: the outstanding request is abandoned.
  - A write whose commit edge has not occurred is not committed.
  - No rsp_valid is produced for the abandoned request.
  - All outputs return to their reset values immediately (asynchronous).
- Boundary cases:
  - LATENCY=2 gives 1 WAIT cycle.
  - Maximum index 2^DEPTH_LOG2-1 is valid.
  - Address 0xFFFF with DEPTH_LOG2=10 maps to index 0x3FF.
- Write and read of the same index cannot both occur in one cycle, because only one request is outstanding.

Test Plan (LATENCY=4, DEPTH_LOG2=10):
1. Reset, then read addr 0x0010 with preloaded mem[8]=0xBEEF, accept at edge k -> req_ready=0 at edges k+1..k+3; rsp_valid=1 only at edge k+4; rsp_rdata=0xBEEF; busy falls after k+4.
2. Write 0x1234 to addr 0x0020, then read 0x0021 presented in the write's RESP cycle -> write ack at k+4; read accepted at k+4; rsp_rdata=0x1234 at edge k+8 (bit 0 ignored).
3. req_valid held high continuously with alternating addresses 0x0002/0x0004 -> accepts at k, k+4, k+8; exactly one rsp_valid per accept; req_valid during WAIT has no effect.
4. Write 0xAAAA to addr 0x0040, assert rst_n=0 at edge k+2 and release, then read 0x0040 -> outputs immediately 0 on reset; no rsp_valid for the aborted write; later read returns the old contents, not 0xAAAA.
5. Write 0x5555 to addr 0xFFFE, then read addr 0x07FE -> both map to index 0x3FF; read returns 0x5555.
6. Read issued, then write 0x0000 issued -> rsp_rdata keeps the read value through the write and during its ack; rsp_valid is a single-cycle pulse each time.

Source files
------------

// File: rtl/multicycle_mem_responder.sv
// rtl/multicycle_mem_responder.sv - fixed-latency data memory with one outstanding request
// Read data or a write acknowledge is returned as a one-cycle pulse LATENCY edges after accept.
module multicycle_mem_responder #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  req_ready,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  busy
);

  localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY) : 1;
  localparam int WORDS = 2 ** DEPTH_LOG2;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                  state;
  state_t                  next_state;
  logic [CNT_W-1:0]        cnt;
  logic                    lat_wr;
  logic [DEPTH_LOG2-1:0]   lat_idx;
  logic [DATA_WIDTH-1:0]   lat_wdata;
  logic [DATA_WIDTH-1:0]   mem [WORDS];
  logic                    accept;
  logic                    commit;
  logic                    unused_addr;

  // Byte-lane bit and bits above the array range do not select a word.
  assign unused_addr = req_addr[0] ^ (|(req_addr >> (DEPTH_LOG2 + 1)));

  assign accept = req_valid & req_ready;
  assign commit = (state == WAIT) && (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    req_ready  = 1'b1;
    busy       = 1'b0;
    rsp_valid  = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) next_state = WAIT;
      end
      WAIT: begin
        req_ready = 1'b0;
        busy      = 1'b1;
        if (cnt == '0) next_state = RESP;
      end
      RESP: begin
        busy       = 1'b1;
        rsp_valid  = 1'b1;
        next_state = req_valid ? WAIT : IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      lat_wr    <= 1'b0;
      lat_idx   <= '0;
      lat_wdata <= '0;
      rsp_rdata <= '0;
    end else begin
      if (accept) begin
        cnt       <= CNT_W'(LATENCY - 2);
        lat_wr    <= req_wr;
        lat_idx   <= req_addr[DEPTH_LOG2:1];
        lat_wdata <= req_wdata;
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - CNT_W'(1);
      end
      // Read data is captured on the same edge a write would commit, so a
      // write always lands before any later read looks at the array.
      if (commit && !lat_wr) begin
        rsp_rdata <= mem[lat_idx];
      end
    end
  end

  // Array is not reset; state is, so a reset before the commit edge drops the write.
  always_ff @(posedge clk) begin
    if (commit && lat_wr) begin
      mem[lat_idx] <= lat_wdata;
    end
  end

endmodule
